// File: rtl/minmax_tracker.sv
// Packet min/max/count tracker fed by a valid/ready sample stream; one result per packet.
// Define MINMAX_SIGNED_EN to order samples as two's-complement instead of unsigned.

module minmax_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         gt
);
    assign lt = (a < b);
    assign gt = (a > b);
endmodule

module minmax_tracker #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_min,
    output logic [N-1:0]  out_max,
    output logic [CW-1:0] out_count,
    output logic          out_overflow
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] COUNT_MAX = '1;

`ifdef MINMAX_SIGNED_EN
    // Flipping the MSB of both operands maps two's-complement order onto unsigned order.
    localparam logic [N-1:0] BIAS = {1'b1, {(N-1){1'b0}}};
`else
    localparam logic [N-1:0] BIAS = '0;
`endif

    state_t        state, next_state;
    logic [N-1:0]  min_q, min_d;
    logic [N-1:0]  max_q, max_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          in_fire;
    logic          data_lt_min;
    logic          data_gt_max;
    logic [N-1:0]  cmp_data, cmp_min, cmp_max;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign in_fire   = in_valid & in_ready;

    assign cmp_data = in_data ^ BIAS;
    assign cmp_min  = min_q ^ BIAS;
    assign cmp_max  = max_q ^ BIAS;

    minmax_cmp #(.W(N)) u_cmp_min (
        .a  (cmp_data),
        .b  (cmp_min),
        .lt (data_lt_min),
        .gt ()
    );

    minmax_cmp #(.W(N)) u_cmp_max (
        .a  (cmp_data),
        .b  (cmp_max),
        .lt (),
        .gt (data_gt_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= next_state;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        next_state = state;
        min_d      = min_q;
        max_d      = max_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    min_d      = in_data;
                    max_d      = in_data;
                    count_d    = CW'(1);
                    ovf_d      = 1'b0;
                    next_state = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    if (data_lt_min) min_d = in_data;
                    if (data_gt_max) max_d = in_data;
                    // Saturate the count and remember that it happened for the rest of the packet.
                    if (count_q == COUNT_MAX) ovf_d = 1'b1;
                    else                      count_d = count_q + CW'(1);
                    if (in_last) next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                    min_d      = '0;
                    max_d      = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign out_min      = min_q;
    assign out_max      = max_q;
    assign out_count    = count_q;
    assign out_overflow = ovf_q;
endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: an 8-bit-count instance plus a 4-bit-count instance for saturation.

module tb_minmax_tracker;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid, out_overflow;
    logic [7:0] out_min, out_max, out_count;

    logic       in_ready4, out_valid4, out_overflow4;
    logic [7:0] out_min4, out_max4;
    logic [3:0] out_count4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    minmax_tracker #(.N(8), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max), .out_count(out_count), .out_overflow(out_overflow)
    );

    minmax_tracker #(.N(8), .CW(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_min(out_min4), .out_max(out_max4), .out_count(out_count4), .out_overflow(out_overflow4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({out_valid, out_min, out_max, out_count, out_overflow, in_ready} !== {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1})
            $display("[TB] FAIL reset_state: got v=%b min=%h max=%h cnt=%0d ovf=%b rdy=%b, expected v=0 min=00 max=00 cnt=0 ovf=0 rdy=1",
                     out_valid, out_min, out_max, out_count, out_overflow, in_ready);
        else passed++;
    endtask

    task automatic test_stream();
        send_beat(8'd5, 1'b0);
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL stream_mid: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
        else passed++;
        send_beat(8'd3, 1'b0);
        send_beat(8'd9, 1'b0);
        send_beat(8'd3, 1'b1);
        checks++;
        if ({out_valid, out_min, out_max, out_count, out_overflow, in_ready} !== {1'b1, 8'd3, 8'd9, 8'd4, 1'b0, 1'b0})
            $display("[TB] FAIL stream_result: got v=%b min=%0d max=%0d cnt=%0d ovf=%b rdy=%b, expected v=1 min=3 max=9 cnt=4 ovf=0 rdy=0",
                     out_valid, out_min, out_max, out_count, out_overflow, in_ready);
        else passed++;
        accept_result();
    endtask

    task automatic test_single_beat();
        send_beat(8'h7F, 1'b1);
        checks++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 8'h7F, 8'h7F, 8'd1})
            $display("[TB] FAIL single_result: got v=%b min=%h max=%h cnt=%0d, expected v=1 min=7f max=7f cnt=1",
                     out_valid, out_min, out_max, out_count);
        else passed++;
        accept_result();
        checks++;
        if ({out_valid, out_min, out_max, out_count, out_overflow, in_ready} !== {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1})
            $display("[TB] FAIL single_cleared: got v=%b min=%h max=%h cnt=%0d ovf=%b rdy=%b, expected v=0 min=00 max=00 cnt=0 ovf=0 rdy=1",
                     out_valid, out_min, out_max, out_count, out_overflow, in_ready);
        else passed++;
    endtask

    task automatic test_backpressure();
        send_beat(8'h20, 1'b0);
        send_beat(8'h40, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, out_min, out_max, out_count, in_ready} !== {1'b1, 8'h20, 8'h40, 8'd2, 1'b0})
                $display("[TB] FAIL backpressure_hold%0d: got v=%b min=%h max=%h cnt=%0d rdy=%b, expected v=1 min=20 max=40 cnt=2 rdy=0",
                         i, out_valid, out_min, out_max, out_count, in_ready);
            else passed++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        accept_result();
        send_beat(8'h10, 1'b1);
        checks++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 8'h10, 8'h10, 8'd1})
            $display("[TB] FAIL backpressure_next: got v=%b min=%h max=%h cnt=%0d, expected v=1 min=10 max=10 cnt=1",
                     out_valid, out_min, out_max, out_count);
        else passed++;
        accept_result();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) send_beat(8'h01, (i == 16));
        checks++;
        if ({out_valid4, out_count4, out_overflow4} !== {1'b1, 4'd15, 1'b1})
            $display("[TB] FAIL sat_cw4: got v=%b cnt=%0d ovf=%b, expected v=1 cnt=15 ovf=1", out_valid4, out_count4, out_overflow4);
        else passed++;
        checks++;
        if ({out_valid, out_count, out_overflow} !== {1'b1, 8'd17, 1'b0})
            $display("[TB] FAIL sat_cw8: got v=%b cnt=%0d ovf=%b, expected v=1 cnt=17 ovf=0", out_valid, out_count, out_overflow);
        else passed++;
        accept_result();
        send_beat(8'h06, 1'b0);
        send_beat(8'h02, 1'b1);
        checks++;
        if ({out_valid4, out_min4, out_max4, out_count4, out_overflow4} !== {1'b1, 8'h02, 8'h06, 4'd2, 1'b0})
            $display("[TB] FAIL sat_next: got v=%b min=%h max=%h cnt=%0d ovf=%b, expected v=1 min=02 max=06 cnt=2 ovf=0",
                     out_valid4, out_min4, out_max4, out_count4, out_overflow4);
        else passed++;
        accept_result();
    endtask

    task automatic test_signed_order();
        logic [7:0] exp_min, exp_max;
`ifdef MINMAX_SIGNED_EN
        exp_min = 8'h80; exp_max = 8'h7F;
`else
        exp_min = 8'h7F; exp_max = 8'h80;
`endif
        send_beat(8'h80, 1'b0);
        send_beat(8'h7F, 1'b1);
        checks++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, exp_min, exp_max, 8'd2})
            $display("[TB] FAIL order: got v=%b min=%h max=%h cnt=%0d, expected v=1 min=%h max=%h cnt=2",
                     out_valid, out_min, out_max, out_count, exp_min, exp_max);
        else passed++;
        accept_result();
    endtask

    task automatic test_equal_and_mid_reset();
        send_beat(8'h33, 1'b0);
        send_beat(8'h33, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({out_valid, out_min, out_max, out_count, in_ready} !== {1'b0, 8'h00, 8'h00, 8'h00, 1'b1})
            $display("[TB] FAIL mid_reset: got v=%b min=%h max=%h cnt=%0d rdy=%b, expected v=0 min=00 max=00 cnt=0 rdy=1",
                     out_valid, out_min, out_max, out_count, in_ready);
        else passed++;
        send_beat(8'h44, 1'b0);
        send_beat(8'h44, 1'b0);
        send_beat(8'h45, 1'b1);
        checks++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 8'h44, 8'h45, 8'd3})
            $display("[TB] FAIL after_reset: got v=%b min=%h max=%h cnt=%0d, expected v=1 min=44 max=45 cnt=3",
                     out_valid, out_min, out_max, out_count);
        else passed++;
        accept_result();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_single_beat();
        test_backpressure();
        test_saturation();
        test_signed_order();
        test_equal_and_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
